// File: rtl/msg_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msg_key_pkg
// Brief    : Shared state encoding, default constants and width helper for the
//            key/message decoder.
// Revision : 1.0 - initial release
// ============================================================================
package msg_key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned c_data_w_def    = 8;
  localparam int unsigned c_msg_len_def   = 8;
  localparam int unsigned c_key_limit_def = 5;
  localparam logic [7:0]  c_xor_mask_def  = 8'hFF;
  localparam int unsigned c_timeout_def   = 1000;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_key_timer.sv
`default_nettype none
// ============================================================================
// Module   : msg_key_timer
// Brief    : Saturating idle counter with clear/enable; expire flags the last
//            idle cycle before the limit. TIMEOUT = 0 disables it entirely.
// Revision : 1.0 - initial release
// ============================================================================
module msg_key_timer
  import msg_key_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_timeout_def
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, clear, enable};
      assign expire   = 1'b0;
    end else begin : g_enabled
      localparam int unsigned    c_w    = cnt_width(TIMEOUT);
      localparam logic [c_w-1:0] c_max  = c_w'(TIMEOUT);
      localparam logic [c_w-1:0] c_last = c_w'(TIMEOUT - 1);

      logic [c_w-1:0] r_count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (enable && (r_count != c_max)) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign expire = enable && !clear && (r_count == c_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/msg_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : msg_key_decoder
// Brief    : Key-validated byte collector: first byte selects per-byte XOR,
//            next MSG_LEN bytes form a message offered on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module msg_key_decoder
  import msg_key_pkg::*;
#(
  parameter int unsigned       DATA_W    = c_data_w_def,
  parameter int unsigned       MSG_LEN   = c_msg_len_def,
  parameter int unsigned       KEY_LIMIT = c_key_limit_def,
  parameter logic [DATA_W-1:0] XOR_MASK  = DATA_W'(c_xor_mask_def),
  parameter int unsigned       TIMEOUT   = c_timeout_def
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      is_new,
  input  logic [DATA_W-1:0]         rx_data,
  output logic [MSG_LEN*DATA_W-1:0] msg_data,
  output logic                      msg_valid,
  input  logic                      msg_ready,
  output logic                      key_err,
  output logic                      timeout_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int unsigned        c_cnt_w    = cnt_width(MSG_LEN);
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(MSG_LEN - 1);
  localparam int unsigned        c_kw       = DATA_W + 1;
  // A limit above the byte range accepts every key; clamp so it fits c_kw bits.
  localparam int unsigned        c_lim_sat  = (KEY_LIMIT > (1 << DATA_W)) ? (1 << DATA_W) : KEY_LIMIT;
  localparam logic [c_kw-1:0]    c_key_lim  = c_kw'(c_lim_sat);

  state_t               r_state;
  logic [MSG_LEN-1:0]   r_key;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_key_ok;
  logic                 w_timer_clr;
  logic                 w_timer_en;
  logic                 w_expire;

  assign w_key_ok    = ({1'b0, rx_data} < c_key_lim);
  assign w_timer_clr = (r_state != COLLECT) || is_new;
  assign w_timer_en  = (r_state == COLLECT);

  msg_key_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_timer_clr),
    .enable (w_timer_en),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_key       <= '0;
      r_count     <= '0;
      msg_data    <= '0;
      msg_valid   <= 1'b0;
      key_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      key_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (is_new) begin
            if (w_key_ok) begin
              r_key   <= rx_data[MSG_LEN-1:0];
              r_count <= '0;
              r_state <= COLLECT;
              busy    <= 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (is_new) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
              if (r_count == c_cnt_w'(i)) begin
                msg_data[i*DATA_W +: DATA_W] <= rx_data ^ (r_key[i] ? XOR_MASK : '0);
              end
            end
            r_count <= r_count + 1'b1;
            if (r_count == c_last_idx) begin
              r_state   <= DONE;
              msg_valid <= 1'b1;
            end
          end else if (w_expire) begin
            timeout_err <= 1'b1;
            r_count     <= '0;
            msg_data    <= '0;
            r_state     <= IDLE;
            busy        <= 1'b0;
          end
        end
        DONE: begin
          // Any strobe here is dropped, even one landing on the handshake cycle.
          if (is_new) begin
            overrun <= 1'b1;
          end
          if (msg_ready) begin
            msg_valid <= 1'b0;
            r_state   <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          msg_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
